// File: rtl/arc4_pkg.sv
// arc4_pkg: shared types and constants for the ARC4 encrypt datapath.
// Holds the top FSM state enum, the sub-cycle phase enum, the KSA
// engine state enum, the default key length and the latency constants.
package arc4_pkg;

    // Default key length in bytes (24-bit key)
    localparam int DEF_KEY_BYTES = 3;

    // Phase lengths in clock cycles
    localparam int INIT_CYC          = 256;
    localparam int KSA_CYC           = 1024;
    localparam int LEN_CYC           = 2;
    localparam int FIN_CYC           = 1;
    localparam int PRGA_CYC_PER_BYTE = 6;

    // Top-level controller states
    typedef enum logic [2:0] {
        IDLE,
        INIT,
        KSA,
        LEN,
        PRGA,
        FIN
    } state_t;

    // Sub-cycle phase inside one KSA iteration or one PRGA byte
    typedef enum logic [2:0] {
        PH1,
        PH2,
        PH3,
        PH4,
        PH5,
        PH6
    } phase_t;

    // States of the INIT+KSA engine
    typedef enum logic [1:0] {
        K_IDLE,
        K_INIT,
        K_RUN
    } ksa_state_t;

    // Total cycles from the accepting edge to rdy for an L-byte message
    function automatic int run_cycles(input int len);
        return INIT_CYC + KSA_CYC + LEN_CYC + FIN_CYC
             + PRGA_CYC_PER_BYTE * len;
    endfunction

endpackage

// File: rtl/arc4_ksa.sv
// arc4_ksa: ARC4 S-box initialisation (S[n]=n) followed by the key
// scheduling pass. Owns the S-memory port while running.
//   clk, rst       : clock, synchronous active-high reset
//   start          : one-cycle request, begins INIT on this edge
//   key            : key bytes, byte 0 in the MSBs; held stable by caller
//   s_rddata       : S-memory read data (1-cycle latency)
//   s_addr/s_wrdata/s_wren : S-memory request
//   init_done      : high during the last INIT cycle
//   done           : high during the last KSA cycle
module arc4_ksa
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = DEF_KEY_BYTES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [7:0]             s_rddata,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_wrdata,
    output logic                   s_wren,
    output logic                   init_done,
    output logic                   done
);

    localparam int KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KIW-1:0] KIDX_LAST = KIW'(KEY_BYTES - 1);

    ksa_state_t     state;
    phase_t         ph;
    logic [7:0]     i;
    logic [7:0]     j;
    logic [7:0]     si;
    logic [KIW-1:0] kidx;

    logic [7:0]     kbytes [KEY_BYTES];
    logic [7:0]     kb;
    logic [7:0]     j_next;

    genvar n;
    generate
        for (n = 0; n < KEY_BYTES; n++) begin : g_kb
            assign kbytes[n] = key[8*(KEY_BYTES-n)-1 -: 8];
        end
    endgenerate

    // kidx tracks i mod KEY_BYTES without a divider
    assign kb     = kbytes[kidx];
    assign j_next = j + s_rddata + kb;

    assign init_done = (state == K_INIT) && (i == 8'hFF);
    assign done      = (state == K_RUN) && (ph == PH4) && (i == 8'hFF);

    // S-memory request; PH2 forwards the new j straight to the address
    always_comb begin
        s_addr   = 8'd0;
        s_wrdata = 8'd0;
        s_wren   = 1'b0;
        unique case (state)
            K_INIT: begin
                s_addr   = i;
                s_wrdata = i;
                s_wren   = 1'b1;
            end
            K_RUN: begin
                case (ph)
                    PH1: s_addr = i;
                    PH2: s_addr = j_next;
                    PH3: begin
                        s_addr   = i;
                        s_wrdata = s_rddata;
                        s_wren   = 1'b1;
                    end
                    PH4: begin
                        s_addr   = j;
                        s_wrdata = si;
                        s_wren   = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= K_IDLE;
            ph    <= PH1;
            i     <= 8'd0;
            j     <= 8'd0;
            si    <= 8'd0;
            kidx  <= '0;
        end else begin
            unique case (state)
                K_IDLE: begin
                    if (start) begin
                        state <= K_INIT;
                        i     <= 8'd0;
                    end
                end
                K_INIT: begin
                    // i wraps to 0, ready for the first KSA iteration
                    i <= i + 8'd1;
                    if (i == 8'hFF) begin
                        state <= K_RUN;
                        ph    <= PH1;
                        j     <= 8'd0;
                        kidx  <= '0;
                    end
                end
                K_RUN: begin
                    case (ph)
                        PH1: ph <= PH2;
                        PH2: begin
                            si <= s_rddata;
                            j  <= j_next;
                            ph <= PH3;
                        end
                        PH3: ph <= PH4;
                        PH4: begin
                            ph   <= PH1;
                            i    <= i + 8'd1;
                            kidx <= (kidx == KIDX_LAST) ? '0
                                                        : kidx + 1'b1;
                            if (i == 8'hFF) state <= K_IDLE;
                        end
                        default: ph <= PH1;
                    endcase
                end
                default: state <= K_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/arc4_encrypt.sv
// arc4_encrypt: ARC4 producer. Runs INIT+KSA (arc4_ksa), reads the
// length byte, runs PRGA and writes the length-prefixed ciphertext.
//   clk, rst          : clock, synchronous active-high reset
//   en, rdy           : start handshake, accepted when both are 1
//   key               : key, latched on the accepting edge
//   s_addr/s_wrdata/s_wren/s_rddata : 256x8 S-memory port
//   pt_addr/pt_rddata : plaintext memory read port
//   ct_addr/ct_wrdata/ct_wren       : ciphertext memory write port
module arc4_encrypt
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = DEF_KEY_BYTES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_wrdata,
    output logic                   s_wren,
    input  logic [7:0]             s_rddata,
    output logic [7:0]             pt_addr,
    input  logic [7:0]             pt_rddata,
    output logic [7:0]             ct_addr,
    output logic [7:0]             ct_wrdata,
    output logic                   ct_wren
);

    state_t                 state;
    phase_t                 ph;
    logic [8*KEY_BYTES-1:0] key_q;
    logic [7:0]             i;
    logic [7:0]             j;
    logic [7:0]             k;
    logic [7:0]             len;
    logic [7:0]             si;
    logic [7:0]             sj;

    logic                   start;
    logic [7:0]             k_s_addr;
    logic [7:0]             k_s_wrdata;
    logic                   k_s_wren;
    logic                   k_init_done;
    logic                   k_done;
    logic [7:0]             j_next;

    // rdy is only ever 1 in IDLE
    assign start  = rdy && en;
    assign j_next = j + s_rddata;

    arc4_ksa #(
        .KEY_BYTES (KEY_BYTES)
    ) u_ksa (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key       (key_q),
        .s_rddata  (s_rddata),
        .s_addr    (k_s_addr),
        .s_wrdata  (k_s_wrdata),
        .s_wren    (k_s_wren),
        .init_done (k_init_done),
        .done      (k_done)
    );

    // Port mux: arc4_ksa owns S during INIT/KSA, PRGA engine otherwise
    always_comb begin
        s_addr    = 8'd0;
        s_wrdata  = 8'd0;
        s_wren    = 1'b0;
        pt_addr   = 8'd0;
        ct_addr   = 8'd0;
        ct_wrdata = 8'd0;
        ct_wren   = 1'b0;
        unique case (state)
            INIT, KSA: begin
                s_addr   = k_s_addr;
                s_wrdata = k_s_wrdata;
                s_wren   = k_s_wren;
            end
            LEN: begin
                // PH1 reads pt[0]; PH2 copies the length to ct[0]
                if (ph == PH2) begin
                    ct_wrdata = pt_rddata;
                    ct_wren   = 1'b1;
                end
            end
            PRGA: begin
                case (ph)
                    PH1: s_addr = i;
                    PH2: s_addr = j_next;
                    PH3: begin
                        s_addr   = i;
                        s_wrdata = s_rddata;
                        s_wren   = 1'b1;
                    end
                    PH4: begin
                        s_addr   = j;
                        s_wrdata = si;
                        s_wren   = 1'b1;
                    end
                    PH5: begin
                        s_addr  = si + sj;
                        pt_addr = k;
                    end
                    PH6: begin
                        ct_addr   = k;
                        ct_wrdata = s_rddata ^ pt_rddata;
                        ct_wren   = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ph    <= PH1;
            rdy   <= 1'b1;
            key_q <= '0;
            i     <= 8'd0;
            j     <= 8'd0;
            k     <= 8'd0;
            len   <= 8'd0;
            si    <= 8'd0;
            sj    <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en) begin
                        key_q <= key;
                        rdy   <= 1'b0;
                        state <= INIT;
                    end
                end
                INIT: begin
                    if (k_init_done) state <= KSA;
                end
                KSA: begin
                    if (k_done) begin
                        state <= LEN;
                        ph    <= PH1;
                    end
                end
                LEN: begin
                    if (ph == PH1) begin
                        ph <= PH2;
                    end else begin
                        len <= pt_rddata;
                        ph  <= PH1;
                        // i pre-incremented for the first byte
                        i   <= 8'd1;
                        j   <= 8'd0;
                        k   <= 8'd1;
                        state <= (pt_rddata == 8'd0) ? FIN : PRGA;
                    end
                end
                PRGA: begin
                    case (ph)
                        PH1: ph <= PH2;
                        PH2: begin
                            si <= s_rddata;
                            j  <= j_next;
                            ph <= PH3;
                        end
                        PH3: begin
                            sj <= s_rddata;
                            ph <= PH4;
                        end
                        PH4: ph <= PH5;
                        PH5: ph <= PH6;
                        PH6: begin
                            ph <= PH1;
                            // stop on k==len so k never wraps to 0
                            if (k == len) begin
                                state <= FIN;
                            end else begin
                                k <= k + 8'd1;
                                i <= i + 8'd1;
                            end
                        end
                        default: ph <= PH1;
                    endcase
                end
                FIN: begin
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arc4_encrypt.sv
// tb_arc4_encrypt: directed vector table plus hand-written sequences
// for reset abort, round trip and the start handshake of arc4_encrypt.
module tb_arc4_encrypt;

    logic        clk;
    logic        rst;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  s_addr;
    logic [7:0]  s_wrdata;
    logic        s_wren;
    logic [7:0]  s_rddata;
    logic [7:0]  pt_addr;
    logic [7:0]  pt_rddata;
    logic [7:0]  ct_addr;
    logic [7:0]  ct_wrdata;
    logic        ct_wren;

    arc4_encrypt #(
        .KEY_BYTES (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .key       (key),
        .s_addr    (s_addr),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .s_rddata  (s_rddata),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .ct_addr   (ct_addr),
        .ct_wrdata (ct_wrdata),
        .ct_wren   (ct_wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] s_mem  [256];
    logic [7:0] pt_mem [256];
    logic [7:0] ct_mem [256];
    logic [7:0] exp_ct [256];

    int         s_wr_total   = 0;
    int         ct_wr_total  = 0;
    int         ct0_total    = 0;
    int         ct_order_err = 0;
    logic [7:0] ct_last      = 8'd0;

    int n_pass = 0;
    int n_chk  = 0;

    // single-port memories with 1-cycle read latency
    always @(posedge clk) begin
        s_rddata  <= s_mem[s_addr];
        pt_rddata <= pt_mem[pt_addr];
        if (s_wren) begin
            s_mem[s_addr] <= s_wrdata;
            s_wr_total    <= s_wr_total + 1;
        end
        if (ct_wren) begin
            ct_mem[ct_addr] <= ct_wrdata;
            ct_wr_total     <= ct_wr_total + 1;
            if (ct_addr == 8'd0)
                ct0_total <= ct0_total + 1;
            else if (ct_addr != 8'(ct_last + 8'd1))
                ct_order_err <= ct_order_err + 1;
            ct_last <= ct_addr;
        end
    end

    typedef struct {
        logic [23:0] key;
        int          len;
        int          pat;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
    endtask

    function automatic void arc4_model(input logic [23:0] k, input int len);
        logic [7:0] s [256];
        logic [7:0] t;
        logic [7:0] kb;
        int         a;
        int         b;
        for (int x = 0; x < 256; x++) s[x] = 8'(x);
        b = 0;
        for (a = 0; a < 256; a++) begin
            kb   = 8'(k >> (8 * (2 - (a % 3))));
            b    = (b + int'(s[a]) + int'(kb)) % 256;
            t    = s[a];
            s[a] = s[b];
            s[b] = t;
        end
        a = 0;
        b = 0;
        exp_ct[0] = 8'(len);
        for (int n = 1; n <= len; n++) begin
            a    = (a + 1) % 256;
            b    = (b + int'(s[a])) % 256;
            t    = s[a];
            s[a] = s[b];
            s[b] = t;
            exp_ct[n] = s[(int'(s[a]) + int'(s[b])) % 256] ^ pt_mem[n];
        end
    endfunction

    task automatic load_pt(input int len, input int pat);
        string txt;
        txt = "Plaintext";
        pt_mem[0] = 8'(len);
        for (int x = 1; x <= len; x++) begin
            case (pat)
                0:       pt_mem[x] = (x <= 9) ? txt[x-1] : 8'd0;
                1:       pt_mem[x] = 8'd0;
                2:       pt_mem[x] = 8'(x * 7 + 3);
                default: pt_mem[x] = 8'(x) ^ 8'h5A;
            endcase
        end
    endtask

    task automatic start_run(input logic [23:0] k);
        @(negedge clk);
        key = k;
        en  = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 4000) begin
            @(posedge clk);
            n++;
            #1;
            if (rdy) break;
        end
    endtask

    task automatic check_ct(input logic [23:0] k, input int len,
                            input string tag);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        arc4_model(k, len);
        for (int x = 0; x <= len; x++) begin
            if (ct_mem[x] !== exp_ct[x]) begin
                bad++;
                if (first < 0) first = x;
            end
        end
        n_chk++;
        if (bad == 0)
            n_pass++;
        else
            $display("FAIL %s ct bytes: %0d wrong, ct[%0d]=%02h expected %02h",
                     tag, bad, first, ct_mem[first], exp_ct[first]);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        int s0;
        int c0;
        int z0;
        int o0;
        load_pt(v.len, v.pat);
        start_run(v.key);
        s0 = s_wr_total;
        c0 = ct_wr_total;
        z0 = ct0_total;
        o0 = ct_order_err;
        wait_done(n);
        chk({tag, " latency"}, n, 1283 + 6 * v.len);
        chk({tag, " s writes"}, s_wr_total - s0, 768 + 2 * v.len);
        chk({tag, " ct writes"}, ct_wr_total - c0, v.len + 1);
        chk({tag, " ct0 writes"}, ct0_total - z0, 1);
        chk({tag, " ct order"}, ct_order_err - o0, 0);
        check_ct(v.key, v.len, tag);
    endtask

    vec_t       vecs [5];
    logic [7:0] exp1 [10];
    logic [7:0] orig [256];

    initial begin
        int n;
        int bad;
        int c0;
        int rose;

        vecs[0] = '{24'h4B6579, 9,   0};
        vecs[1] = '{24'h000018, 0,   1};
        vecs[2] = '{24'($urandom), 255, 2};
        vecs[3] = '{24'h000001, 1,   1};
        vecs[4] = '{24'hFFFFFF, 16,  3};
        exp1 = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8,
                 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

        rst = 1'b1;
        en  = 1'b0;
        key = 24'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset rdy", int'(rdy), 1);
        chk("reset s_wren", int'(s_wren), 0);
        chk("reset ct_wren", int'(ct_wren), 0);
        chk("reset addrs", int'({s_addr, pt_addr, ct_addr}), 0);
        chk("reset wrdata", int'({s_wrdata, ct_wrdata}), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 5; v++)
            run_vec(vecs[v], $sformatf("vec%0d", v));

        // known-answer for key "Key", plaintext "Plaintext"
        run_vec(vecs[0], "kat");
        bad = 0;
        for (int x = 0; x < 10; x++)
            if (ct_mem[x] !== exp1[x]) bad++;
        chk("kat bytes wrong", bad, 0);

        // round trip: encrypting the ciphertext restores the plaintext
        load_pt(32, 2);
        for (int x = 0; x <= 32; x++) orig[x] = pt_mem[x];
        start_run(24'h000018);
        wait_done(n);
        chk("rt enc latency", n, 1475);
        for (int x = 1; x <= 32; x++) pt_mem[x] = ct_mem[x];
        start_run(24'h000018);
        wait_done(n);
        chk("rt dec latency", n, 1475);
        bad = 0;
        for (int x = 0; x <= 32; x++)
            if (ct_mem[x] !== orig[x]) bad++;
        chk("rt bytes wrong", bad, 0);

        // reset during KSA iteration 100
        load_pt(9, 0);
        start_run(24'h4B6579);
        c0 = ct_wr_total;
        repeat (655) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort rdy", int'(rdy), 1);
        chk("abort s_wren", int'(s_wren), 0);
        chk("abort ct_wren", int'(ct_wren), 0);
        chk("abort ct writes", ct_wr_total - c0, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle after abort", int'(s_wren || ct_wren), 0);
        run_vec(vecs[0], "after abort");

        // busy en pulse ignored; en held across FIN restarts
        load_pt(9, 0);
        start_run(24'h4B6579);
        n    = 0;
        rose = 0;
        while (n < 4000 && rose == 0) begin
            @(negedge clk);
            if (n == 100) begin
                key = 24'h123456;
                en  = 1'b1;
            end else if (n == 101) begin
                en = 1'b0;
            end else if (n == 1330) begin
                key = 24'hABCDEF;
                en  = 1'b1;
            end
            @(posedge clk);
            n++;
            #1;
            if (n == 101) chk("busy en ignored", int'(rdy), 0);
            if (rdy) rose = 1;
        end
        chk("held latency", n, 1337);
        check_ct(24'h4B6579, 9, "held run1");
        c0 = ct_wr_total;
        @(posedge clk);
        #1;
        chk("held restart", int'(rdy), 0);
        en = 1'b0;
        wait_done(n);
        chk("run2 latency", n, 1337);
        chk("run2 ct writes", ct_wr_total - c0, 10);
        check_ct(24'hABCDEF, 9, "held run2");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
